signed_comparator: RTL and testbench
====================================

Name: signed_comparator

Overview:
- Registered signed magnitude comparator for the processor datapath; feeds branch/set-condition logic.
- Compares two two's-complement operands and reports greater-than, less-than and equal flags, one clock after the operands are presented.
- Primary result `out` is 1 iff signed A > signed B.

Parameters:
- WIDTH, 16, operand width in bits; must be 2 or more.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands on A/B are valid this cycle.
- A  input  WIDTH  operand A, two's complement.
- B  input  WIDTH  operand B, two's complement.
- out_valid  output  1  result flags are valid (registered in_valid).
- out  output  1  1 iff $signed(A) > $signed(B).
- lt  output  1  1 iff $signed(A) < $signed(B).
- eq  output  1  1 iff A == B (bitwise).

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - rst_n low asynchronously forces out_valid=0, out=0, lt=0, eq=0, independent of clk.
  - Deassertion takes effect from the next rising edge.
- Latency is exactly 1 cycle:
  - in_valid=1 at edge N captures out/lt/eq computed from that cycle's A/B, and sets out_valid=1 after edge N.
  - in_valid=0 at edge N sets out_valid=0 and holds out/lt/eq at their previous values.
- Throughput is one compare per cycle. There is no backpressure and no stall input.
- Signed comparison rule:
  - Operands differ in MSB: the operand with MSB=0 is greater.
  - Otherwise compare bits WIDTH-2..0 as unsigned.
  - Must match the $signed relational operators for every input pair.
- Exactly one of out, lt, eq is 1 whenever out_valid=1.
  - Equal operands: out=0, lt=0, eq=1.
- No overflow cases: the comparison never uses A-B without a sign-extension bit.
- Boundary cases (WIDTH=16):
  - 0x7FFF vs 0x8000: out=1.
  - 0x8000 vs 0x7FFF: lt=1.
  - 0xFFFF vs 0x0000: lt=1.
  - 0x8000 vs 0x8000: eq=1.
- Reset mid-stream: a pending capture is discarded. The first valid result after release needs a fresh in_valid.
- X on A/B while in_valid=0 must not propagate into out/lt/eq.

Optional Feature:
- Macro CMP_UNSIGNED_EN.
- Defined:
  - Adds input port is_unsigned (1 bit), sampled with in_valid.
  - is_unsigned=1: out/lt/eq use unsigned magnitude, so 0x8000 > 0x7FFF gives out=1.
  - is_unsigned=0: signed behaviour as above.
- Undefined: the port is absent and the comparison is always signed.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> out_valid=0, out=0, lt=0, eq=0 immediately, before any clock edge.
- Sweep: start A=0x7FFF, B=0x8000; each cycle A-=1, B+=1 with in_valid=1.
  - While A≥0x0000 (i.e. A in 0x0000..0x7FFF): out=1, lt=0 one cycle after each pair.
  - At A=0x8000, B=0x7FFF: out=0, lt=1.
- Equality: A=B=0x1234, then A=B=0x8000 -> eq=1, out=0, lt=0.
- Sign edge: A=0xFFFF (-1), B=0x0000 -> lt=1. Swapped operands -> out=1.
- Valid gating:
  - Pulse in_valid=1 with A=5, B=3, then in_valid=0 with A=1, B=9.
  - Required: out_valid 1 then 0; out stays 1 during the idle cycle.
- With CMP_UNSIGNED_EN: is_unsigned=1, A=0x8000, B=0x7FFF -> out=1. Same operands with is_unsigned=0 -> lt=1.

Source files
------------

// File: rtl/signed_comparator_if.sv
// Operand/result bundle for signed_comparator.
// With CMP_UNSIGNED_EN defined, carries the per-compare is_unsigned select.
interface signed_comparator_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef CMP_UNSIGNED_EN
    logic             is_unsigned;
`endif
    logic             out_valid;
    logic             out;
    logic             lt;
    logic             eq;

`ifdef CMP_UNSIGNED_EN
    modport master (
        output in_valid, A, B, is_unsigned,
        input  out_valid, out, lt, eq
    );
    modport slave (
        input  in_valid, A, B, is_unsigned,
        output out_valid, out, lt, eq
    );
`else
    modport master (
        output in_valid, A, B,
        input  out_valid, out, lt, eq
    );
    modport slave (
        input  in_valid, A, B,
        output out_valid, out, lt, eq
    );
`endif
endinterface

// File: rtl/signed_comparator.sv
// Registered two's-complement comparator: gt/lt/eq flags one cycle after in_valid.
// Optional CMP_UNSIGNED_EN adds a per-compare unsigned mode via bus.is_unsigned.
module signed_comparator #(
    parameter int unsigned WIDTH = 16
) (
    input logic            clk,
    input logic            rst_n,
    signed_comparator_if.slave bus
);
    localparam int unsigned Msb = WIDTH - 1;

    logic uns;
`ifdef CMP_UNSIGNED_EN
    assign uns = bus.is_unsigned;
`else
    assign uns = 1'b0;
`endif

    logic msb_differ;
    logic low_gt;
    logic gt_d;
    logic lt_d;
    logic eq_d;

    always_comb begin
        msb_differ = bus.A[Msb] ^ bus.B[Msb];
        low_gt     = bus.A[Msb-1:0] > bus.B[Msb-1:0];
        eq_d       = bus.A == bus.B;
        // On differing MSBs the winner is MSB=0 when signed, MSB=1 when unsigned.
        gt_d       = msb_differ ? (bus.A[Msb] == uns) : low_gt;
        lt_d       = ~gt_d & ~eq_d;
    end

    logic out_valid_q;
    logic out_q;
    logic lt_q;
    logic eq_q;

    // Flags only load under in_valid, so idle-cycle X on A/B never reaches them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                out_q <= gt_d;
                lt_q  <= lt_d;
                eq_q  <= eq_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.lt        = lt_q;
    assign bus.eq        = eq_q;
endmodule

// File: tb/tb_signed_comparator.sv
// Directed bench for signed_comparator with a queue scoreboard of {out_valid,out,lt,eq}.
module tb_signed_comparator;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    signed_comparator_if #(.WIDTH(W)) bus ();
    signed_comparator #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] sb_q[$];
    logic [2:0] held = 3'b000;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    // Independent reference: plain SV relational operators.
    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic uns);
        if (uns) return {a > b, a < b, a == b};
        return {$signed(a) > $signed(b), $signed(a) < $signed(b), a == b};
    endfunction

    task automatic apply(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic uns, input logic [2:0] exp, input string tag);
        @(negedge clk);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
`ifdef CMP_UNSIGNED_EN
        bus.is_unsigned = uns;
`endif
        if (v) held = exp;
        sb_q.push_back({v, held});
        @(posedge clk);
        #1;
        check(tag, {bus.out_valid, bus.out, bus.lt, bus.eq}, sb_q.pop_front());
    endtask

    logic [W-1:0] a;

    initial begin
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
`ifdef CMP_UNSIGNED_EN
        bus.is_unsigned = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #1 check("reset_initial", {bus.out_valid, bus.out, bus.lt, bus.eq}, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep A down / B up (A+B == 0xFFFF), in three windows incl. both boundaries.
        for (int i = 0; i < 256; i++) begin
            a = 16'(16'h7FFF - i);
            apply(1'b1, a, ~a, 1'b0, model(a, ~a, 1'b0), "sweep_top");
        end
        for (int i = 0; i < 256; i++) begin
            a = 16'(16'h0080 - i);
            apply(1'b1, a, ~a, 1'b0, model(a, ~a, 1'b0), "sweep_zero");
        end
        for (int i = 0; i < 128; i++) begin
            a = 16'(16'h807F - i);
            apply(1'b1, a, ~a, 1'b0, model(a, ~a, 1'b0), "sweep_bottom");
        end

        // Boundary constants
        apply(1'b1, 16'h7FFF, 16'h8000, 1'b0, 3'b100, "max_vs_min");
        apply(1'b1, 16'h8000, 16'h7FFF, 1'b0, 3'b010, "min_vs_max");
        apply(1'b1, 16'h1234, 16'h1234, 1'b0, 3'b001, "eq_1234");
        apply(1'b1, 16'h8000, 16'h8000, 1'b0, 3'b001, "eq_8000");
        apply(1'b1, 16'hFFFF, 16'h0000, 1'b0, 3'b010, "neg1_vs_0");
        apply(1'b1, 16'h0000, 16'hFFFF, 1'b0, 3'b100, "0_vs_neg1");
        apply(1'b1, 16'hFFFE, 16'hFFFF, 1'b0, 3'b010, "neg2_vs_neg1");

        // Valid gating: flags hold while idle, even with X operands
        apply(1'b1, 16'd5, 16'd3, 1'b0, 3'b100, "gate_valid");
        apply(1'b0, 16'd1, 16'd9, 1'b0, 3'b000, "gate_idle");
        apply(1'b0, 'x, 'x, 1'b0, 3'b000, "x_idle");
        apply(1'b1, 16'd2, 16'd7, 1'b0, 3'b010, "after_x");

        // Asynchronous reset mid-cycle clears outputs before any edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_async", {bus.out_valid, bus.out, bus.lt, bus.eq}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        held  = 3'b000;

        // Reset while a capture is pending: the capture is dropped
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A        = 16'd9;
        bus.B        = 16'd1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 check("reset_pending", {bus.out_valid, bus.out, bus.lt, bus.eq}, 4'b0000);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        apply(1'b0, 16'd9, 16'd1, 1'b0, 3'b000, "post_reset_idle");
        apply(1'b1, 16'd9, 16'd1, 1'b0, 3'b100, "post_reset_fresh");

`ifdef CMP_UNSIGNED_EN
        apply(1'b1, 16'h8000, 16'h7FFF, 1'b1, 3'b100, "uns_gt");
        apply(1'b1, 16'h8000, 16'h7FFF, 1'b0, 3'b010, "sgn_lt");
        apply(1'b1, 16'hFFFF, 16'h0000, 1'b1, 3'b100, "uns_ffff");
        apply(1'b1, 16'h8000, 16'h8000, 1'b1, 3'b001, "uns_eq");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
